// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and next-state function for the 5-bit Galois LFSR.
package lfsr_pkg;

   localparam int LFSR_W = 5;

   // Feedback taps 5 and 3, XORed in when the bit shifted out is 1.
   localparam logic [LFSR_W-1:0] TAP_MASK = 5'b10100;

   // Value used after reset and whenever a zero seed is written.
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'h01;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   // One Galois step: shift right and fold the output bit back through the taps.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return (q >> 1) ^ (q[0] ? TAP_MASK : '0);
   endfunction

endpackage

// File: rtl/lfsr5_step.sv
// 5-bit LFSR register with step enable and synchronous seed load.
// A zero seed would lock the LFSR, so it is replaced by DEFAULT_SEED.
module lfsr5_step
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] q
);

   // Load has priority over stepping; zero seeds are substituted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_SEED;
      end else if (load) begin
         q <= (load_val == '0) ? DEFAULT_SEED : load_val;
      end else if (en) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/lfsr_share_sched.sv
// Round-robin scheduler sharing one LFSR among NREQ requesters.
// Stream handshake: a word transfers on any cycle where dvalid and dready are
// both high; dvalid never drops and dout never changes until that happens.
module lfsr_share_sched
   import lfsr_pkg::*;
#(
   parameter int                NREQ       = 4,
   parameter int                LEN_W      = 4,
   parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*LEN_W-1:0]   req_len,
   output logic [NREQ-1:0]         gnt,
   output logic [LFSR_W-1:0]       dout,
   output logic                    dvalid,
   input  logic                    dready,
   output logic                    done,
   input  logic                    seed_we,
   input  logic [LFSR_W-1:0]       seed,
   output logic                    seed_err,
   output state_e                  fsm_state
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = LEN_W + 1;

   state_e            state, state_n;
   logic [IDX_W-1:0]  ptr, ptr_n;
   logic [IDX_W-1:0]  win, win_n;
   logic [IDX_W-1:0]  pick, off;
   logic [NREQ-1:0]   rot;
   logic              any_req;
   logic [LEN_W-1:0]  len_raw;
   logic [CNT_W-1:0]  len_sel;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [NREQ-1:0]   gnt_n;
   logic              done_n, seed_err_n;
   logic              beat;

   assign dvalid    = (state == BURST);
   assign beat      = dvalid && dready;
   assign fsm_state = state;

   // Rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      rot     = '0;
      off     = '0;
      any_req = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         rot[k] = req[(int'(ptr) + k) % NREQ];
      end
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off     = IDX_W'(k);
            any_req = 1'b1;
         end
      end
      pick = IDX_W'((int'(off) + int'(ptr)) % NREQ);
   end

   // Winner's burst length; a zero field means the full 2**LEN_W beats.
   always_comb begin
      len_raw = req_len[int'(pick)*LEN_W +: LEN_W];
      len_sel = (len_raw == '0) ? CNT_W'(1 << LEN_W) : {1'b0, len_raw};
   end

   // Next-state, grant, counter and pulse outputs.
   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      win_n      = win;
      cnt_n      = cnt;
      gnt_n      = gnt;
      done_n     = 1'b0;
      seed_err_n = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_n = BURST;
               win_n   = pick;
               gnt_n   = NREQ'(1) << pick;
               cnt_n   = len_sel;
            end
         end
         BURST: begin
            seed_err_n = seed_we;
            if (dready) begin
               cnt_n = cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  done_n  = 1'b1;
                  ptr_n   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
               end
            end
         end
      endcase
   end

   // Scheduler state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         win      <= '0;
         cnt      <= '0;
         gnt      <= '0;
         done     <= 1'b0;
         seed_err <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         win      <= win_n;
         cnt      <= cnt_n;
         gnt      <= gnt_n;
         done     <= done_n;
         seed_err <= seed_err_n;
      end
   end

   // Seed writes are only honoured while idle; they override a same-cycle step.
   lfsr5_step #(
      .RESET_SEED (RESET_SEED)
   ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .en       (beat),
      .load     (seed_we && (state == IDLE)),
      .load_val (seed),
      .q        (dout)
   );

endmodule
